// File: rtl/grng_stats_sink_if.sv
// Handshake and result bus between the Gaussian sample source and grng_stats_sink.
// master: start/in_valid/in_data/thresh; slave: in_ready/busy/done and window results.
// Parameters DW (sample width) and LOG2_N (log2 window length) size the result fields.
interface grng_stats_sink_if #(
  parameter int DW     = 16,
  parameter int LOG2_N = 10
);
  logic                     start;
  logic                     in_valid;
  logic [DW-1:0]            in_data;
  logic                     in_ready;
  logic [DW-1:0]            thresh;
  logic                     busy;
  logic                     done;
  logic [DW+LOG2_N-1:0]     sum;
  logic [2*DW+LOG2_N-1:0]   sum_sq;
  logic [DW-1:0]            min_val;
  logic [DW-1:0]            max_val;
  logic [LOG2_N:0]          outlier_cnt;

  modport master (
    output start, in_valid, in_data, thresh,
    input  in_ready, busy, done, sum, sum_sq, min_val, max_val, outlier_cnt
  );

  modport slave (
    input  start, in_valid, in_data, thresh,
    output in_ready, busy, done, sum, sum_sq, min_val, max_val, outlier_cnt
  );
endinterface

// File: rtl/grng_stats_sink.sv
// Windowed statistics (sum, sum of squares, min, max, outlier count) over 2^LOG2_N samples.
// Latency: one sample per cycle; results and a one-cycle done appear on the edge after the Nth accept.
// Backpressure: in_ready is high only while a window is open (ACCUM); start is ignored outside IDLE.
// Ports: clk, rst_n (async active-low), bus (grng_stats_sink_if.slave).
module grng_stats_sink #(
  parameter int DW     = 16,
  parameter int LOG2_N = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  grng_stats_sink_if.slave    bus
);
  localparam int SW = DW + LOG2_N;      // signed sum width
  localparam int QW = 2 * DW + LOG2_N;  // sum of squares width
  localparam int OW = LOG2_N + 1;       // outlier count width (can reach N)

  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state;

  logic signed [SW-1:0] acc_sum;
  logic [QW-1:0]        acc_sq;
  logic signed [DW-1:0] acc_min;
  logic signed [DW-1:0] acc_max;
  logic [OW-1:0]        acc_out;
  logic [LOG2_N-1:0]    cnt;
  logic [DW-1:0]        thresh_q;

  logic                 in_ready_r;
  logic                 busy_r;
  logic                 done_r;
  logic signed [SW-1:0] res_sum;
  logic [QW-1:0]        res_sq;
  logic signed [DW-1:0] res_min;
  logic signed [DW-1:0] res_max;
  logic [OW-1:0]        res_out;

  logic signed [DW-1:0]   x;
  logic signed [2*DW-1:0] prod;
  logic [DW:0]            x_ext;
  logic [DW:0]            x_abs;
  logic                   accept;
  logic                   last;
  logic signed [SW-1:0]   nxt_sum;
  logic [QW-1:0]          nxt_sq;
  logic signed [DW-1:0]   nxt_min;
  logic signed [DW-1:0]   nxt_max;
  logic [OW-1:0]          nxt_out;

  assign x      = bus.in_data;
  assign accept = (state == ACCUM) && bus.in_valid;
  assign last   = accept && (cnt == {LOG2_N{1'b1}});

  // Operands are sign-extended to 2*DW before multiplying, so (-2^(DW-1))^2 is exact
  // and the (always non-negative) product can be accumulated as unsigned.
  assign prod  = x * x;

  // Magnitude at DW+1 bits so the most negative sample does not wrap.
  assign x_ext = {x[DW-1], x};
  assign x_abs = x[DW-1] ? (~x_ext + {{DW{1'b0}}, 1'b1}) : x_ext;

  always_comb begin
    nxt_sum = acc_sum + {{LOG2_N{x[DW-1]}}, x};
    nxt_sq  = acc_sq + {{LOG2_N{1'b0}}, prod};
    nxt_min = (x < acc_min) ? x : acc_min;
    nxt_max = (x > acc_max) ? x : acc_max;
    nxt_out = acc_out;
    if (x_abs > {1'b0, thresh_q}) begin
      nxt_out = acc_out + {{LOG2_N{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc_sum    <= '0;
      acc_sq     <= '0;
      acc_min    <= '0;
      acc_max    <= '0;
      acc_out    <= '0;
      cnt        <= '0;
      thresh_q   <= '0;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      res_sum    <= '0;
      res_sq     <= '0;
      res_min    <= '0;
      res_max    <= '0;
      res_out    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= ACCUM;
            acc_sum    <= '0;
            acc_sq     <= '0;
            acc_min    <= {1'b0, {(DW-1){1'b1}}};
            acc_max    <= {1'b1, {(DW-1){1'b0}}};
            acc_out    <= '0;
            cnt        <= '0;
            thresh_q   <= bus.thresh;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b1;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_sum <= nxt_sum;
            acc_sq  <= nxt_sq;
            acc_min <= nxt_min;
            acc_max <= nxt_max;
            acc_out <= nxt_out;
            cnt     <= cnt + {{(LOG2_N-1){1'b0}}, 1'b1};
          end
          // Results take the post-update values so the Nth sample is included.
          if (last) begin
            state      <= IDLE;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            res_sum    <= nxt_sum;
            res_sq     <= nxt_sq;
            res_min    <= nxt_min;
            res_max    <= nxt_max;
            res_out    <= nxt_out;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.sum         = res_sum;
  assign bus.sum_sq      = res_sq;
  assign bus.min_val     = res_min;
  assign bus.max_val     = res_max;
  assign bus.outlier_cnt = res_out;
endmodule
